// File: rtl/game_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : game_ctrl_fsm
//  Description : Turn controller for the connect-four datapath. Clears the
//                board, accepts a column choice, hands it to the move
//                validator, writes the validated column words back to the
//                on/off and player board memories, then asks the logic unit
//                for a win check before rotating to the next player.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_ctrl_fsm #(
    parameter int NUM_COLS    = 7,
    parameter int NUM_ROWS    = 6,
    parameter int NUM_PLAYERS = 2,
    parameter int ADDR_W      = 3,
    parameter int PLAYER_W    = 1,
    parameter int MOVE_W      = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         play,
    input  logic                         valid_input,
    input  logic [ADDR_W-1:0]            decoder_addr,
    input  logic                         validator_done,
    input  logic                         validator_ok,
    input  logic [NUM_ROWS-1:0]          validator_onoff,
    input  logic [NUM_ROWS*PLAYER_W-1:0] validator_player,
    input  logic                         logic_done,
    input  logic                         logic_win,
    output logic [PLAYER_W-1:0]          cur_player,
    output logic                         game_finished,
    output logic [PLAYER_W-1:0]          winner,
    output logic                         draw,
    output logic                         validator_go,
    output logic                         logic_go,
    output logic                         onoff_write,
    output logic                         player_write,
    output logic [ADDR_W-1:0]            mem_address,
    output logic [NUM_ROWS-1:0]          write_to_onoff,
    output logic [NUM_ROWS*PLAYER_W-1:0] write_to_player,
    output logic                         clearing
);

    // State encoding
    localparam logic [2:0] C_CLEAR        = 3'd0;
    localparam logic [2:0] C_WAIT_INPUT   = 3'd1;
    localparam logic [2:0] C_CHECK_INPUT  = 3'd2;
    localparam logic [2:0] C_UPDATE_GAME  = 3'd3;
    localparam logic [2:0] C_CHECK_WINNER = 3'd4;
    localparam logic [2:0] C_END_GAME     = 3'd5;

    // One extra bit on the column bound so NUM_COLS == 2**ADDR_W still compares correctly
    localparam logic [ADDR_W:0]     C_NUM_COLS    = (ADDR_W+1)'(NUM_COLS);
    localparam logic [ADDR_W-1:0]   C_LAST_COL    = ADDR_W'(NUM_COLS - 1);
    localparam logic [PLAYER_W-1:0] C_LAST_PLAYER = PLAYER_W'(NUM_PLAYERS - 1);
    localparam logic [MOVE_W-1:0]   C_MAX_MOVES   = MOVE_W'(NUM_COLS * NUM_ROWS);

    logic [2:0]                   state_q,     state_d;
    logic                         play_q;
    logic [ADDR_W-1:0]            clr_idx_q,   clr_idx_d;
    logic [ADDR_W-1:0]            col_q,       col_d;
    logic [NUM_ROWS-1:0]          onoff_q,     onoff_d;
    logic [NUM_ROWS*PLAYER_W-1:0] player_q,    player_d;
    logic [PLAYER_W-1:0]          cur_q,       cur_d;
    logic [MOVE_W-1:0]            move_cnt_q,  move_cnt_d;
    logic                         finished_q,  finished_d;
    logic                         draw_q,      draw_d;
    logic [PLAYER_W-1:0]          winner_q,    winner_d;

    logic play_rise;
    assign play_rise = play & ~play_q;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= C_CLEAR;
            play_q     <= 1'b0;
            clr_idx_q  <= '0;
            col_q      <= '0;
            onoff_q    <= '0;
            player_q   <= '0;
            cur_q      <= '0;
            move_cnt_q <= '0;
            finished_q <= 1'b0;
            draw_q     <= 1'b0;
            winner_q   <= '0;
        end else begin
            state_q    <= state_d;
            play_q     <= play;
            clr_idx_q  <= clr_idx_d;
            col_q      <= col_d;
            onoff_q    <= onoff_d;
            player_q   <= player_d;
            cur_q      <= cur_d;
            move_cnt_q <= move_cnt_d;
            finished_q <= finished_d;
            draw_q     <= draw_d;
            winner_q   <= winner_d;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        col_d      = col_q;
        onoff_d    = onoff_q;
        player_d   = player_q;
        cur_d      = cur_q;
        move_cnt_d = move_cnt_q;
        finished_d = finished_q;
        draw_d     = draw_q;
        winner_d   = winner_q;
        case (state_q)
            C_CLEAR: begin
                // Game status is wiped during the sweep so the new game starts clean
                cur_d      = '0;
                move_cnt_d = '0;
                finished_d = 1'b0;
                draw_d     = 1'b0;
                winner_d   = '0;
                if (clr_idx_q == C_LAST_COL) begin
                    clr_idx_d = '0;
                    state_d   = C_WAIT_INPUT;
                end else begin
                    clr_idx_d = clr_idx_q + ADDR_W'(1);
                end
            end
            C_WAIT_INPUT: begin
                if (play_rise && valid_input && ({1'b0, decoder_addr} < C_NUM_COLS)) begin
                    col_d   = decoder_addr;
                    state_d = C_CHECK_INPUT;
                end
            end
            C_CHECK_INPUT: begin
                if (validator_done) begin
                    onoff_d  = validator_onoff;
                    player_d = validator_player;
                    state_d  = validator_ok ? C_UPDATE_GAME : C_WAIT_INPUT;
                end
            end
            C_UPDATE_GAME: begin
                move_cnt_d = move_cnt_q + MOVE_W'(1);
                state_d    = C_CHECK_WINNER;
            end
            C_CHECK_WINNER: begin
                if (logic_done) begin
                    if (logic_win) begin
                        winner_d   = cur_q;
                        finished_d = 1'b1;
                        state_d    = C_END_GAME;
                    end else if (move_cnt_q == C_MAX_MOVES) begin
                        draw_d     = 1'b1;
                        finished_d = 1'b1;
                        state_d    = C_END_GAME;
                    end else begin
                        cur_d   = (cur_q == C_LAST_PLAYER) ? '0 : cur_q + PLAYER_W'(1);
                        state_d = C_WAIT_INPUT;
                    end
                end
            end
            C_END_GAME: begin
                if (play_rise) begin
                    state_d = C_CLEAR;
                end
            end
            default: begin
                state_d = C_CLEAR;
            end
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        validator_go    = 1'b0;
        logic_go        = 1'b0;
        onoff_write     = 1'b0;
        player_write    = 1'b0;
        clearing        = 1'b0;
        mem_address     = '0;
        write_to_onoff  = '0;
        write_to_player = '0;
        case (state_q)
            C_CLEAR: begin
                onoff_write  = 1'b1;
                player_write = 1'b1;
                clearing     = 1'b1;
                mem_address  = clr_idx_q;
            end
            C_CHECK_INPUT: begin
                validator_go = 1'b1;
                mem_address  = col_q;
            end
            C_UPDATE_GAME: begin
                onoff_write     = 1'b1;
                player_write    = 1'b1;
                mem_address     = col_q;
                write_to_onoff  = onoff_q;
                write_to_player = player_q;
            end
            C_CHECK_WINNER: begin
                logic_go = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign cur_player    = cur_q;
    assign game_finished = finished_q;
    assign winner        = winner_q;
    assign draw          = draw_q;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_ctrl_fsm
//  Description : Scoreboard bench for game_ctrl_fsm. A default-sized instance
//                covers clear, moves, rejected inputs, win and mid-game reset;
//                a 2x2 three-player instance covers rotation and draw.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_ctrl_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // Default instance signals
    logic       play, valid_input, validator_done, validator_ok, logic_done, logic_win;
    logic [2:0] decoder_addr;
    logic [5:0] v_onoff, v_player;
    logic [0:0] cur_player, winner;
    logic       game_finished, draw, validator_go, logic_go, onoff_write, player_write, clearing;
    logic [2:0] mem_address;
    logic [5:0] w_onoff, w_player;

    // Small instance signals
    logic       play_b, valid_b, vdone_b, vok_b, ldone_b, lwin_b;
    logic [0:0] daddr_b;
    logic [1:0] von_b;
    logic [3:0] vpl_b;
    logic [1:0] cur_b, win_b;
    logic       fin_b, draw_b, vgo_b, lgo_b, onw_b, plw_b, clr_b;
    logic [0:0] maddr_b;
    logic [1:0] won_b;
    logic [3:0] wpl_b;

    game_ctrl_fsm dut (
        .clk(clk), .reset(reset), .play(play), .valid_input(valid_input),
        .decoder_addr(decoder_addr), .validator_done(validator_done),
        .validator_ok(validator_ok), .validator_onoff(v_onoff),
        .validator_player(v_player), .logic_done(logic_done), .logic_win(logic_win),
        .cur_player(cur_player), .game_finished(game_finished), .winner(winner),
        .draw(draw), .validator_go(validator_go), .logic_go(logic_go),
        .onoff_write(onoff_write), .player_write(player_write),
        .mem_address(mem_address), .write_to_onoff(w_onoff),
        .write_to_player(w_player), .clearing(clearing)
    );

    game_ctrl_fsm #(
        .NUM_COLS(2), .NUM_ROWS(2), .NUM_PLAYERS(3),
        .ADDR_W(1), .PLAYER_W(2), .MOVE_W(3)
    ) dut_b (
        .clk(clk), .reset(reset), .play(play_b), .valid_input(valid_b),
        .decoder_addr(daddr_b), .validator_done(vdone_b),
        .validator_ok(vok_b), .validator_onoff(von_b),
        .validator_player(vpl_b), .logic_done(ldone_b), .logic_win(lwin_b),
        .cur_player(cur_b), .game_finished(fin_b), .winner(win_b),
        .draw(draw_b), .validator_go(vgo_b), .logic_go(lgo_b),
        .onoff_write(onw_b), .player_write(plw_b),
        .mem_address(maddr_b), .write_to_onoff(won_b),
        .write_to_player(wpl_b), .clearing(clr_b)
    );

    int total = 0;
    int bad   = 0;

    // Expected-event queues: board writes, validator requests, game-over events
    logic [31:0] wq[$];
    logic [31:0] vq[$];
    logic [31:0] fq[$];
    logic [31:0] fq_b[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pkw(input logic we_on, input logic we_pl, input logic clr,
                                        input logic [2:0] ad, input logic [5:0] d1,
                                        input logic [5:0] d2);
        return {14'b0, we_on, we_pl, clr, ad, d1, d2};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_clear();
        for (int i = 0; i < 7; i++) wq.push_back(pkw(1'b1, 1'b1, 1'b1, 3'(i), 6'd0, 6'd0));
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write, a new
    // validator request, or a game-over event
    logic vgo_prev = 1'b0, fin_prev = 1'b0, fin_b_prev = 1'b0;
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            vgo_prev   = 1'b0;
            fin_prev   = 1'b0;
            fin_b_prev = 1'b0;
        end else begin
            if (onoff_write || player_write) begin
                if (wq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got addr=%0d onoff=%b required none", mem_address, w_onoff);
                end else begin
                    chk("board_write", pkw(onoff_write, player_write, clearing, mem_address, w_onoff, w_player), wq.pop_front());
                end
            end
            if (validator_go && !vgo_prev) begin
                if (vq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_validator_go: got addr=%0d required none", mem_address);
                end else begin
                    chk("validator_addr", 32'(mem_address), vq.pop_front());
                end
            end
            if (game_finished && !fin_prev) begin
                if (fq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_finish: got winner=%0d draw=%0d required none", winner, draw);
                end else begin
                    chk("finish_result", 32'({winner, draw}), fq.pop_front());
                end
            end
            if (fin_b && !fin_b_prev) begin
                if (fq_b.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_finish_b: got winner=%0d draw=%0d required none", win_b, draw_b);
                end else begin
                    chk("finish_result_b", 32'({win_b, draw_b}), fq_b.pop_front());
                end
            end
            vgo_prev   = validator_go;
            fin_prev   = game_finished;
            fin_b_prev = fin_b;
        end
    end

    // One move: play pulse, validator answer 4 cycles after request, then logic answer
    task automatic do_move(input bit b, input int addr, input logic [5:0] on, input logic [5:0] pl,
                           input bit ok, input bit win, input bit stop);
        int n;
        if (!b) begin
            decoder_addr = 3'(addr); valid_input = 1'b1; play = 1'b1;
            vq.push_back(32'(addr));
        end else begin
            daddr_b = 1'(addr); valid_b = 1'b1; play_b = 1'b1;
        end
        tick();
        play = 1'b0; valid_input = 1'b0; play_b = 1'b0; valid_b = 1'b0;
        n = 0;
        while (((b ? vgo_b : validator_go) !== 1'b1) && n < 20) begin tick(); n++; end
        chk("validator_go_seen", 32'(n < 20), 32'd1);
        if (n >= 20) return;
        repeat (4) tick();
        if (!b) begin
            validator_done = 1'b1; validator_ok = ok; v_onoff = on; v_player = pl;
            if (ok) wq.push_back(pkw(1'b1, 1'b1, 1'b0, 3'(addr), on, pl));
        end else begin
            vdone_b = 1'b1; vok_b = ok; von_b = on[1:0]; vpl_b = pl[3:0];
        end
        tick();
        validator_done = 1'b0; validator_ok = 1'b0; vdone_b = 1'b0; vok_b = 1'b0;
        if (!ok) return;
        n = 0;
        while (((b ? lgo_b : logic_go) !== 1'b1) && n < 20) begin tick(); n++; end
        chk("logic_go_seen", 32'(n < 20), 32'd1);
        if (stop || n >= 20) return;
        if (!b) begin logic_done = 1'b1; logic_win = win; end
        else    begin ldone_b = 1'b1;    lwin_b = win;    end
        tick();
        logic_done = 1'b0; logic_win = 1'b0; ldone_b = 1'b0; lwin_b = 1'b0;
    endtask

    initial begin
        play = 0; valid_input = 0; validator_done = 0; validator_ok = 0;
        logic_done = 0; logic_win = 0; decoder_addr = '0; v_onoff = '0; v_player = '0;
        play_b = 0; valid_b = 0; vdone_b = 0; vok_b = 0; ldone_b = 0; lwin_b = 0;
        daddr_b = '0; von_b = '0; vpl_b = '0;
        reset = 1'b1;

        // Reset and clear sweep
        push_clear();
        repeat (2) tick();
        reset = 1'b0;
        chk("reset_clearing", 32'(clearing), 32'd1);
        chk("reset_cur_player", 32'(cur_player), 32'd0);
        chk("reset_finished", 32'({game_finished, draw, winner}), 32'd0);
        chk("reset_validator_go", 32'(validator_go), 32'd0);
        repeat (7) tick();
        chk("wait_after_clear", 32'(clearing), 32'd0);
        chk("wait_cur_player", 32'(cur_player), 32'd0);

        // Legal non-winning move by player 0
        do_move(1'b0, 3, 6'b000001, 6'b000000, 1'b1, 1'b0, 1'b0);
        chk("rotate_to_p1", 32'(cur_player), 32'd1);

        // Validator rejects the move
        do_move(1'b0, 2, 6'b000011, 6'b000001, 1'b0, 1'b0, 1'b0);
        chk("reject_keeps_player", 32'(cur_player), 32'd1);
        chk("reject_back_to_wait", 32'(validator_go), 32'd0);

        // Out-of-range column and invalid encoding are both ignored
        decoder_addr = 3'd7; valid_input = 1'b1; play = 1'b1;
        tick(); play = 1'b0;
        repeat (4) tick();
        chk("addr7_ignored", 32'({validator_go, clearing}), 32'd0);
        decoder_addr = 3'd1; valid_input = 1'b0; play = 1'b1;
        tick(); play = 1'b0;
        repeat (4) tick();
        chk("invalid_ignored", 32'(validator_go), 32'd0);

        // Player 1 wins; play is already held when the game ends
        do_move(1'b0, 4, 6'b000011, 6'b000010, 1'b1, 1'b0, 1'b1);
        play = 1'b1;
        tick();
        fq.push_back(32'b10);
        logic_done = 1'b1; logic_win = 1'b1;
        tick();
        logic_done = 1'b0; logic_win = 1'b0;
        repeat (5) tick();
        chk("win_held", 32'({game_finished, winner, draw, clearing}), 32'b1100);
        play = 1'b0;
        tick();
        push_clear();
        play = 1'b1;
        tick();
        play = 1'b0;
        chk("restart_clearing", 32'(clearing), 32'd1);
        repeat (7) tick();
        chk("restart_state", 32'({clearing, cur_player, game_finished, winner, draw}), 32'd0);

        // Mid-operation reset while waiting on the logic unit
        do_move(1'b0, 5, 6'b000001, 6'b000000, 1'b1, 1'b0, 1'b0);
        chk("pre_reset_player", 32'(cur_player), 32'd1);
        do_move(1'b0, 5, 6'b000011, 6'b000010, 1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        chk("midreset_clearing", 32'(clearing), 32'd1);
        chk("midreset_logic_go", 32'(logic_go), 32'd0);
        chk("midreset_player", 32'(cur_player), 32'd0);
        push_clear();
        reset = 1'b0;
        logic_done = 1'b1; logic_win = 1'b1;
        tick();
        logic_done = 1'b0; logic_win = 1'b0;
        repeat (6) tick();
        chk("late_done_ignored", 32'({game_finished, winner, clearing}), 32'd0);

        // Small board: three-player rotation ending in a draw
        chk("b_rot0", 32'(cur_b), 32'd0);
        do_move(1'b1, 0, 6'b000001, 6'b000000, 1'b1, 1'b0, 1'b0);
        chk("b_rot1", 32'(cur_b), 32'd1);
        do_move(1'b1, 1, 6'b000001, 6'b000001, 1'b1, 1'b0, 1'b0);
        chk("b_rot2", 32'(cur_b), 32'd2);
        do_move(1'b1, 0, 6'b000011, 6'b000100, 1'b1, 1'b0, 1'b0);
        chk("b_rot3", 32'(cur_b), 32'd0);
        chk("b_not_done", 32'(fin_b), 32'd0);
        fq_b.push_back(32'b001);
        do_move(1'b1, 1, 6'b000011, 6'b000001, 1'b1, 1'b0, 1'b0);
        chk("b_draw", 32'({fin_b, draw_b, win_b}), 32'b1100);

        // All expected events must have been consumed
        repeat (3) tick();
        chk("write_queue_empty", 32'(wq.size()), 32'd0);
        chk("vgo_queue_empty", 32'(vq.size()), 32'd0);
        chk("finish_queue_empty", 32'(fq.size() + fq_b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/game_ctrl_fsm.md
Name: game_ctrl_fsm

Overview:
Parametrised top-level turn controller for the connect-four game datapath: sequences board clear, input acceptance, move validation, board write, and win/draw check. Supports configurable board width/height and player count. Uses done-handshakes with the move validator and game logic unit. Owns the write port of the on/off and player board memories (one column word per address).

Parameters:
NUM_COLS, 7, board columns = memory depth
NUM_ROWS, 6, board rows = on/off word width
NUM_PLAYERS, 2, players in rotation (2..4)
ADDR_W, 3, column address width (2**ADDR_W >= NUM_COLS)
PLAYER_W, 1, player id width (2**PLAYER_W >= NUM_PLAYERS)
MOVE_W, 6, move counter width (2**MOVE_W > NUM_COLS*NUM_ROWS)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
play  in  1  play button, active-high level (already de-inverted); rising edge detected internally
valid_input  in  1  decoder says switch input is a legal encoding
decoder_addr  in  ADDR_W  column selected by decoder
validator_done  in  1  validator result valid this cycle
validator_ok  in  1  move legal (qualified by validator_done)
validator_onoff  in  NUM_ROWS  new on/off column word
validator_player  in  NUM_ROWS*PLAYER_W  new player column word
logic_done  in  1  logic unit result valid this cycle
logic_win  in  1  current player has won (qualified by logic_done)
cur_player  out  PLAYER_W  player whose turn it is
game_finished  out  1  game over (win or draw)
winner  out  PLAYER_W  winning player, valid when game_finished && !draw
draw  out  1  board filled with no winner
validator_go  out  1  request to validator
logic_go  out  1  request to logic unit
onoff_write  out  1  on/off board write enable
player_write  out  1  player board write enable
mem_address  out  ADDR_W  board address
write_to_onoff  out  NUM_ROWS  on/off write data
write_to_player  out  NUM_ROWS*PLAYER_W  player write data
clearing  out  1  board clear in progress

Behaviour:
- All outputs are decoded from registered state only; there is no combinational path from any input to any output.
- play_rise = play & ~play_q, where play_q is registered; play_q resets to 0.
- States: CLEAR, WAIT_INPUT, CHECK_INPUT, UPDATE_GAME, CHECK_WINNER, END_GAME.
- Reset (any state, any cycle) -> CLEAR. Also on reset: clr_idx=0, cur_player=0, move_cnt=0, game_finished=0, draw=0, winner=0, col_reg=0, latched data=0.
- CLEAR:
  - onoff_write=player_write=1, clearing=1, mem_address=clr_idx, write data all-zero.
  - clr_idx increments each cycle. At clr_idx==NUM_COLS-1 -> WAIT_INPUT, clr_idx=0.
  - Lasts exactly NUM_COLS cycles. On exit, cur_player/move_cnt/game_finished/draw/winner are 0.
- WAIT_INPUT:
  - play_rise && valid_input && decoder_addr<NUM_COLS -> CHECK_INPUT; col_reg<=decoder_addr.
  - Otherwise stay. An out-of-range address is ignored.
- CHECK_INPUT:
  - validator_go=1, mem_address=col_reg; held until validator_done.
  - On done: latch validator_onoff/validator_player. Then ok -> UPDATE_GAME; !ok -> WAIT_INPUT with player unchanged.
- UPDATE_GAME:
  - Exactly 1 cycle. onoff_write=player_write=1, mem_address=col_reg, data=latched words.
  - move_cnt++ -> CHECK_WINNER.
- CHECK_WINNER:
  - logic_go=1, held until logic_done.
  - On done with logic_win: winner<=cur_player, game_finished<=1 -> END_GAME.
  - Else if move_cnt==NUM_COLS*NUM_ROWS: draw<=1, game_finished<=1 -> END_GAME.
  - Else cur_player <= (cur_player==NUM_PLAYERS-1) ? 0 : cur_player+1 -> WAIT_INPUT.
- END_GAME:
  - Outputs hold winner/draw/game_finished. play_rise -> CLEAR.
  - A held play causes no second rise.
- In states other than WAIT_INPUT and END_GAME, play edges are dropped, not queued.
- validator_done/logic_done are ignored outside their respective states.
- mem_address=0 and all write enables=0 in states not listed above.

Test Plan:
- Reset: hold reset 2 cycles -> 7 CLEAR cycles writing addr 0..6 with zero data, clearing=1; then WAIT_INPUT, cur_player=0, all flags 0.
- Legal move: addr=3, valid_input=1, play pulse; validator_done+ok after 4 cycles with onoff=6'b000001 -> one cycle onoff_write=player_write=1 at addr 3 with that data; logic_done, win=0 -> cur_player=1.
- Illegal/ignored input:
  - validator_ok=0 -> no write, cur_player unchanged.
  - decoder_addr=7 with NUM_COLS=7 -> stays WAIT_INPUT, validator_go never asserted.
- Win: player 1 move, logic_win=1 -> game_finished=1, winner=1, draw=0. Held play gives no restart; new play edge -> CLEAR sweep, then cur_player=0.
- Draw and rotation: NUM_COLS=2, NUM_ROWS=2, NUM_PLAYERS=3, 4 legal non-winning moves.
  - cur_player sequence 0,1,2,0.
  - After 4th check -> draw=1, game_finished=1.
- Mid-operation reset: assert reset while in CHECK_WINNER with logic_go=1 -> next cycle CLEAR. logic_go=0, move_cnt=0; a late logic_done is ignored.
